// File: rtl/ob_c2h_pkg.sv
// Shared definitions for the card-to-host stream transmitter.
// Optional feature macro used by ob_c2h_tx: OB_C2H_IRQ_EN.
package ob_c2h_pkg;

  localparam int unsigned RAM_DW_DEF  = 128;
  localparam int unsigned AXIS_DW_DEF = 64;
  localparam int unsigned LEN_W_DEF   = 16;

  localparam logic [7:0] KEEP_ALL = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    IRQ    = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/ob_c2h_fifo2.sv
// Two-entry prefetch FIFO between the RAM read port and the beat packer.
// The head entry is presented combinationally; reset flushes the contents.
module ob_c2h_fifo2
  import ob_c2h_pkg::*;
#(
  parameter int unsigned DW = RAM_DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;

  // Storage array: written on push, no reset needed (count gates validity)
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/ob_c2h_tx.sv
// Card-to-host transmitter: reads len_words 128-bit RAM words from base_addr
// and sends each as two 64-bit AXI-Stream beats (low half first), then
// optionally raises a user interrupt. Optional macro: OB_C2H_IRQ_EN.
module ob_c2h_tx
  import ob_c2h_pkg::*;
#(
  parameter int unsigned RAM_DW  = RAM_DW_DEF,
  parameter int unsigned AXIS_DW = AXIS_DW_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned IRQ_IDX = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          base_addr,
  input  logic [LEN_W-1:0]     len_words,
  output logic                 busy,
  output logic                 done,
  output logic                 RdEn,
  output logic [31:0]          RdAddr,
  input  logic [RAM_DW-1:0]    RdData,
  output logic [AXIS_DW-1:0]   s_axis_c2h_tdata_0,
  output logic [AXIS_DW/8-1:0] s_axis_c2h_tkeep_0,
  output logic                 s_axis_c2h_tlast_0,
  output logic                 s_axis_c2h_tvalid_0,
  input  logic                 s_axis_c2h_tready_0,
  output logic [3:0]           usr_irq_req,
  input  logic [3:0]           usr_irq_ack,
  input  logic                 msi_enable
);

  state_t              state, state_next;
  logic [31:0]         base_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    rd_cnt;
  logic [LEN_W-1:0]    tx_cnt;
  logic                rd_pend;
  logic                half;
  logic [1:0]          fifo_count;
  logic [RAM_DW-1:0]   fifo_head;
  logic                rd_room;
  logic                beat_fire;
  logic                word_pop;
  logic                last_fire;
  logic                unused_inputs;

  ob_c2h_fifo2 #(.DW(RAM_DW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (rd_pend),
    .pop     (word_pop),
    .wr_data (RdData),
    .rd_data (fifo_head),
    .count   (fifo_count)
  );

  // Read issue and stream outputs, all derived from registered state
  always_comb begin
    rd_room   = ({1'b0, fifo_count} + {2'b00, rd_pend}) < 3'd2;
    RdEn      = (state == STREAM) && (rd_cnt < len_q) && rd_room;
    RdAddr    = RdEn ? (base_q + 32'(rd_cnt)) : '0;

    s_axis_c2h_tvalid_0 = (state == STREAM) && (fifo_count != 2'd0);
    s_axis_c2h_tdata_0  = '0;
    s_axis_c2h_tkeep_0  = '0;
    s_axis_c2h_tlast_0  = 1'b0;
    if (s_axis_c2h_tvalid_0) begin
      s_axis_c2h_tdata_0 = half ? fifo_head[RAM_DW-1:AXIS_DW] : fifo_head[AXIS_DW-1:0];
      s_axis_c2h_tkeep_0 = KEEP_ALL;
      s_axis_c2h_tlast_0 = half && (tx_cnt == len_q - LEN_W'(1));
    end

    beat_fire = s_axis_c2h_tvalid_0 && s_axis_c2h_tready_0;
    word_pop  = beat_fire && half;
    last_fire = beat_fire && s_axis_c2h_tlast_0;
  end

  // Captured parameters, read/send counters, in-flight flag and beat phase
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q  <= '0;
      len_q   <= '0;
      rd_cnt  <= '0;
      tx_cnt  <= '0;
      rd_pend <= 1'b0;
      half    <= 1'b0;
    end else begin
      rd_pend <= RdEn;
      if (state == IDLE && start) begin
        base_q <= base_addr;
        len_q  <= len_words;
        rd_cnt <= '0;
        tx_cnt <= '0;
        half   <= 1'b0;
      end else begin
        if (RdEn)      rd_cnt <= rd_cnt + LEN_W'(1);
        if (beat_fire) half   <= ~half;
        if (word_pop)  tx_cnt <= tx_cnt + LEN_W'(1);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = (len_words == '0) ? DONE : STREAM;
      end
      STREAM: begin
        if (last_fire) begin
`ifdef OB_C2H_IRQ_EN
          state_next = msi_enable ? IRQ : DONE;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef OB_C2H_IRQ_EN
      IRQ: begin
        if (usr_irq_ack[IRQ_IDX]) state_next = DONE;
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy        = (state == STREAM) || (state == IRQ);
    done        = (state == DONE);
    usr_irq_req = '0;
`ifdef OB_C2H_IRQ_EN
    if (state == IRQ) usr_irq_req[IRQ_IDX] = 1'b1;
`endif
  end

  // Ack bits other than IRQ_IDX (and everything IRQ-related when disabled) are not used
  assign unused_inputs = &{1'b0, usr_irq_ack, msi_enable};

endmodule

// File: tb/tb_ob_c2h_tx.sv
// Scoreboard bench for ob_c2h_tx: expected beats and read addresses are queued
// when a transfer is started and compared as the DUT produces them.
module tb_ob_c2h_tx;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  base_addr;
  logic [15:0]  len_words;
  logic         busy, done, RdEn;
  logic [31:0]  RdAddr;
  logic [127:0] RdData;
  logic [63:0]  tdata;
  logic [7:0]   tkeep;
  logic         tlast, tvalid, tready;
  logic [3:0]   usr_irq_req;
  logic [3:0]   usr_irq_ack;
  logic         msi_enable;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] addr_q[$];
  beat_t       exp_b;
  int          vectors = 0;
  int          miscompares = 0;
  int          beats_seen = 0;
  int          issued = 0;
  int          popped = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;

  ob_c2h_tx dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .base_addr           (base_addr),
    .len_words           (len_words),
    .busy                (busy),
    .done                (done),
    .RdEn                (RdEn),
    .RdAddr              (RdAddr),
    .RdData              (RdData),
    .s_axis_c2h_tdata_0  (tdata),
    .s_axis_c2h_tkeep_0  (tkeep),
    .s_axis_c2h_tlast_0  (tlast),
    .s_axis_c2h_tvalid_0 (tvalid),
    .s_axis_c2h_tready_0 (tready),
    .usr_irq_req         (usr_irq_req),
    .usr_irq_ack         (usr_irq_ack),
    .msi_enable          (msi_enable)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ram_word(input logic [31:0] a);
    return {32'hA0A0_A0A0, a, 32'hB0B0_B0B0, a};
  endfunction

  // RAM model: data one cycle after RdEn, garbage otherwise
  always @(posedge clk) begin
    if (RdEn) RdData <= ram_word(RdAddr);
    else      RdData <= {$urandom, $urandom, $urandom, $urandom};
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: read addresses, beats, occupancy and AXIS stability
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (RdEn) begin
        issued++;
        chk("occupancy_le2", ((issued - popped) <= 2), 1);
        if (addr_q.size() == 0) chk("rdaddr_extra", RdEn, 0);
        else chk("rdaddr", RdAddr, addr_q.pop_front());
      end
      if (prev_stall) begin
        chk("stall_tvalid", tvalid, 1);
        chk("stall_tdata", tdata, prev_data);
        chk("stall_tlast", tlast, prev_last);
      end
      if (tvalid) chk("tkeep", tkeep, 8'hFF);
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          chk("beat_extra", tvalid & tready, 0);
        end else begin
          exp_b = exp_q.pop_front();
          chk("tdata", tdata, exp_b.data);
          chk("tlast", tlast, exp_b.last);
        end
        if (beats_seen % 2 == 1) popped++;
        beats_seen++;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  task automatic start_frame(input logic [31:0] base, input logic [15:0] len);
    logic [31:0] a;
    beats_seen = 0;
    issued     = 0;
    popped     = 0;
    for (int unsigned w = 0; w < len; w++) begin
      a = base + w;
      addr_q.push_back(a);
      exp_q.push_back('{data: {32'hB0B0_B0B0, a}, last: 1'b0});
      exp_q.push_back('{data: {32'hA0A0_A0A0, a}, last: (w == len - 1)});
    end
    base_addr = base;
    len_words = len;
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (!done && n < max) begin
      tick();
      n++;
    end
    chk(tag, done, 1);
  endtask

  // Completes a frame after its last beat, servicing the IRQ if one is raised
  task automatic finish_frame();
    int n = 0;
`ifdef OB_C2H_IRQ_EN
    if (msi_enable) begin
      while (usr_irq_req == 4'h0 && n < 20) begin
        tick();
        n++;
      end
      for (int i = 0; i < 10; i++) begin
        chk("irq_req_held", usr_irq_req, 4'b0001);
        chk("irq_no_done", done, 0);
        if (i == 5) msi_enable = 1'b0;
        tick();
      end
      usr_irq_ack = 4'b0001;
      chk("irq_req_at_ack", usr_irq_req, 4'b0001);
      tick();
      usr_irq_ack = 4'b0000;
      msi_enable  = 1'b1;
      chk("irq_req_drop", usr_irq_req, 4'h0);
      chk("irq_done", done, 1);
    end else begin
      wait_done("done_no_msi", 20);
      chk("no_irq_req", usr_irq_req, 4'h0);
    end
`else
    wait_done("done_after_tlast", 20);
    chk("irq_req_tied", usr_irq_req, 4'h0);
`endif
    tick();
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    chk("drain_beats", exp_q.size(), 0);
    chk("drain_addrs", addr_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rden"}, RdEn, 0);
    chk({tag, "_rdaddr"}, RdAddr, 0);
    chk({tag, "_tvalid"}, tvalid, 0);
    chk({tag, "_tlast"}, tlast, 0);
    chk({tag, "_tdata"}, tdata, 0);
    chk({tag, "_tkeep"}, tkeep, 0);
    chk({tag, "_irq"}, usr_irq_req, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int done_cyc;
    int done_cnt;
    logic active;
    logic irq_seen;

    rst = 1'b1; start = 1'b0; base_addr = '0; len_words = '0;
    tready = 1'b1; usr_irq_ack = 4'h0; msi_enable = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Basic transfer with latency and back-to-back throughput checks
    start_frame(32'h10, 16'd3);
    chk("lat_busy", busy, 1);
    chk("lat_rden_c1", RdEn, 1);
    chk("lat_tvalid_c1", tvalid, 0);
    tick();
    chk("lat_tvalid_c2", tvalid, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("basic_no_bubble", tvalid, 1);
      chk("basic_tlast_pos", tlast, (i == 5));
      tick();
    end
    finish_frame();

    // Zero length: no reads, no beats, no IRQ, a single done pulse
    base_addr = 32'h40; len_words = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    done_cyc = 0; done_cnt = 0; active = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      active = active | RdEn | tvalid | busy | (usr_irq_req != 4'h0);
      tick();
    end
    chk("zero_done_timing", (done_cyc >= 1 && done_cyc <= 2), 1);
    chk("zero_done_pulses", done_cnt, 1);
    chk("zero_quiet", active, 0);

    // Random backpressure, msi off, with a start pulse that must be ignored
    msi_enable = 1'b0;
    start_frame(32'h200, 16'd8);
    n = 0; irq_seen = 1'b0;
    while (!done && n < 400) begin
      tready = 1'($urandom_range(0, 1));
      if (n == 5) begin
        start = 1'b1; base_addr = 32'hDEAD_0000; len_words = 16'd2;
      end else begin
        start = 1'b0;
      end
      irq_seen = irq_seen | (usr_irq_req != 4'h0);
      tick();
      n++;
    end
    start  = 1'b0;
    tready = 1'b1;
    chk("bp_irq_absent", irq_seen, 0);
    chk("bp_beats", beats_seen, 16);
    finish_frame();

    // Address wrap across 0xFFFF_FFFF
    start_frame(32'hFFFF_FFFE, 16'd4);
    wait_done("wrap_done", 50);
    chk("wrap_beats", beats_seen, 8);
    finish_frame();

    // Reset mid-frame, then a fresh full frame with the IRQ path
    msi_enable = 1'b1;
    start_frame(32'h300, 16'd8);
    n = 0;
    while (beats_seen < 3 && n < 50) begin
      tick();
      n++;
    end
    chk("pre_reset_beats", beats_seen, 3);
    tready = 1'b0;
    rst    = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst    = 1'b0;
    tready = 1'b1;
    exp_q.delete();
    addr_q.delete();
    tick();
    chk("post_reset_idle", tvalid | RdEn | busy, 0);
    start_frame(32'h400, 16'd8);
    n = 0;
    while (beats_seen < 16 && n < 100) begin
      tick();
      n++;
    end
    chk("post_reset_beats", beats_seen, 16);
    finish_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
